// File: rtl/instruction_buffer_pkg.sv
// Shared types and sizing for the fetch-to-dispatch instruction buffer.
// Both the buffer and its push compactor import this package.
package instruction_buffer_pkg;

  localparam int IB_SZ          = 32;
  localparam int IB_IDX_BITS    = $clog2(IB_SZ);
  localparam int IB_PUSH_WIDTH  = 4;
  localparam int N              = 3;
  localparam int POP_W          = $clog2(N + 1);
  localparam int PUSH_CNT_W     = $clog2(IB_PUSH_WIDTH + 1);
  localparam int PUSH_IDX_W     = $clog2(IB_PUSH_WIDTH);

  typedef logic [IB_IDX_BITS-1:0] IB_IDX;
  typedef logic [IB_IDX_BITS:0]   IB_CNT;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        is_branch;
    logic        bp_taken;
    logic [31:0] bp_target;
  } FETCH_PACKET;

  function automatic IB_CNT min_cnt(input IB_CNT a, input IB_CNT b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/instruction_buffer_push_compactor.sv
// Packs the sparse valid fetch lanes into a dense, lane-ordered array
// and counts them; purely combinational.
module ib_push_compactor
  import instruction_buffer_pkg::*;
(
  input  FETCH_PACKET             lanes [IB_PUSH_WIDTH],
  output FETCH_PACKET             dense [IB_PUSH_WIDTH],
  output logic [PUSH_CNT_W-1:0]   push_n
);

  logic [PUSH_CNT_W-1:0] idx;

  always_comb begin
    dense = '{default: '0};
    idx   = '0;
    for (int i = 0; i < IB_PUSH_WIDTH; i++) begin
      if (lanes[i].valid) begin
        dense[idx[PUSH_IDX_W-1:0]] = lanes[i];
        idx = idx + 1'b1;
      end
    end
    push_n = idx;
  end

endmodule

// File: rtl/instruction_buffer.sv
// Circular instruction buffer between fetch and dispatch: all-or-nothing
// bundle push, up to N in-order pops per cycle, full flush on mispredict.
module instruction_buffer
  import instruction_buffer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  FETCH_PACKET       fetch_packet     [IB_PUSH_WIDTH],
  output IB_CNT             ib_free_slots,
  input  logic              flush,
  output FETCH_PACKET       dispatch_packets [N],
  input  logic [POP_W-1:0]  num_pops,
  output IB_CNT             ib_count,
  output logic              overflow_err
);

  FETCH_PACKET           dense [IB_PUSH_WIDTH];
  logic [PUSH_CNT_W-1:0] push_n;
  FETCH_PACKET           mem_q [IB_SZ];

  IB_IDX head_q, head_d;
  IB_IDX tail_q, tail_d;
  IB_CNT count_q, count_d;
  IB_CNT free_q, free_d;
  logic  ovf_q, ovf_d;

  IB_CNT eff_pops;
  logic  push_ok;
  logic  push_wr;

  ib_push_compactor u_compactor (
    .lanes  (fetch_packet),
    .dense  (dense),
    .push_n (push_n)
  );

  // Free check uses the pre-pop count: slots freed this cycle are not reusable yet.
  always_comb begin
    eff_pops = min_cnt(IB_CNT'(num_pops), count_q);
    push_ok  = IB_CNT'(push_n) <= free_q;
    push_wr  = push_ok && !flush && (push_n != '0);

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d = head_q + IB_IDX'(eff_pops);
      if (push_ok) begin
        tail_d  = tail_q + IB_IDX'(push_n);
        count_d = count_q + IB_CNT'(push_n) - eff_pops;
      end else begin
        count_d = count_q - eff_pops;
        ovf_d   = 1'b1;
      end
    end
    free_d = IB_CNT'(IB_SZ) - count_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      free_q  <= IB_CNT'(IB_SZ);
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      free_q  <= free_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage holds data only, so it is not reset.
  always_ff @(posedge clock) begin
    if (push_wr) begin
      for (int j = 0; j < IB_PUSH_WIDTH; j++) begin
        if (PUSH_CNT_W'(j) < push_n) begin
          mem_q[tail_q + IB_IDX'(j)] <= dense[j];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      dispatch_packets[i]       = mem_q[head_q + IB_IDX'(i)];
      dispatch_packets[i].valid = IB_CNT'(i) < count_q;
    end
  end

  assign ib_free_slots = free_q;
  assign ib_count      = count_q;
  assign overflow_err  = ovf_q;

endmodule

// File: tb/tb_instruction_buffer.sv
// Directed bench for instruction_buffer with a small occupancy/PC model
// for the wrap-around run.
module tb_instruction_buffer;
  import instruction_buffer_pkg::*;

  logic              clock;
  logic              reset;
  FETCH_PACKET       fetch_packet     [IB_PUSH_WIDTH];
  IB_CNT             ib_free_slots;
  logic              flush;
  FETCH_PACKET       dispatch_packets [N];
  logic [POP_W-1:0]  num_pops;
  IB_CNT             ib_count;
  logic              overflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_buffer dut (
    .clock            (clock),
    .reset            (reset),
    .fetch_packet     (fetch_packet),
    .ib_free_slots    (ib_free_slots),
    .flush            (flush),
    .dispatch_packets (dispatch_packets),
    .num_pops         (num_pops),
    .ib_count         (ib_count),
    .overflow_err     (overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_push(input logic [3:0] mask, input logic [31:0] base_pc);
    for (int i = 0; i < IB_PUSH_WIDTH; i++) begin
      fetch_packet[i]           = '0;
      fetch_packet[i].valid     = mask[i];
      fetch_packet[i].pc        = base_pc + 32'(4 * i);
      fetch_packet[i].inst      = 32'hA000_0000 + base_pc + 32'(4 * i);
      fetch_packet[i].is_branch = (i == 2);
      fetch_packet[i].bp_target = 32'hB000_0000 + 32'(i);
    end
  endtask

  task automatic idle();
    set_push(4'b0000, 32'h0);
    num_pops = '0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_count"}, 64'(ib_count), 64'd0);
    check({tag, "_free"},  64'(ib_free_slots), 64'd32);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_v%0d", tag, i), 64'(dispatch_packets[i].valid), 64'd0);
  endtask

  int    mcount;
  logic [31:0] mhead_pc, mtail_pc;
  int    eff;
  logic  acc;

  initial begin
    reset = 1'b0;
    idle();
    #12;
    check_empty("reset");
    check("reset_ovf", 64'(overflow_err), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // full-width push
    set_push(4'b1111, 32'h0);
    step();
    idle();
    check("p4_count", 64'(ib_count), 64'd4);
    check("p4_free",  64'(ib_free_slots), 64'd28);
    check("p4_pc0",   64'(dispatch_packets[0].pc), 64'h0);
    check("p4_pc1",   64'(dispatch_packets[1].pc), 64'h4);
    check("p4_pc2",   64'(dispatch_packets[2].pc), 64'h8);
    for (int i = 0; i < N; i++)
      check($sformatf("p4_v%0d", i), 64'(dispatch_packets[i].valid), 64'd1);

    // sparse mask compaction
    do_flush();
    set_push(4'b0110, 32'h10);
    step();
    idle();
    check("cmp_count", 64'(ib_count), 64'd2);
    check("cmp_pc0",   64'(dispatch_packets[0].pc), 64'h14);
    check("cmp_pc1",   64'(dispatch_packets[1].pc), 64'h18);
    check("cmp_br1",   64'(dispatch_packets[1].is_branch), 64'd1);
    check("cmp_tgt1",  64'(dispatch_packets[1].bp_target), 64'hB000_0002);
    check("cmp_v0",    64'(dispatch_packets[0].valid), 64'd1);
    check("cmp_v2",    64'(dispatch_packets[2].valid), 64'd0);

    // fill to 30, then overflow with a concurrent pop
    do_flush();
    for (int k = 0; k < 7; k++) begin
      set_push(4'b1111, 32'h1000 + 32'(16 * k));
      step();
    end
    set_push(4'b0011, 32'h1070);
    step();
    idle();
    check("fill_count", 64'(ib_count), 64'd30);
    check("fill_free",  64'(ib_free_slots), 64'd2);
    check("fill_ovf",   64'(overflow_err), 64'd0);
    check("fill_pc0",   64'(dispatch_packets[0].pc), 64'h1000);
    set_push(4'b1111, 32'h2000);
    num_pops = 2'd3;
    step();
    idle();
    check("ovf_count", 64'(ib_count), 64'd27);
    check("ovf_free",  64'(ib_free_slots), 64'd5);
    check("ovf_flag",  64'(overflow_err), 64'd1);
    check("ovf_pc0",   64'(dispatch_packets[0].pc), 64'h100C);

    // wrap-around against a reference model
    do_flush();
    check("wrap_ovf_sticky", 64'(overflow_err), 64'd1);
    mcount   = 0;
    mhead_pc = 32'h4000;
    mtail_pc = 32'h4000;
    for (int c = 0; c < 40; c++) begin
      set_push(4'b1111, mtail_pc);
      num_pops = 2'd3;
      step();
      idle();
      acc = (4 <= 32 - mcount);
      eff = (mcount < 3) ? mcount : 3;
      if (acc) mtail_pc = mtail_pc + 32'd16;
      mhead_pc = mhead_pc + 32'(4 * eff);
      mcount   = mcount + (acc ? 4 : 0) - eff;
      check($sformatf("wrap%0d_count", c), 64'(ib_count), 64'(mcount));
      for (int i = 0; i < N; i++) begin
        if (i < mcount)
          check($sformatf("wrap%0d_pc%0d", c, i), 64'(dispatch_packets[i].pc),
                64'(mhead_pc + 32'(4 * i)));
      end
    end

    // flush wins over simultaneous push and pop
    do_flush();
    set_push(4'b1111, 32'h5000); step();
    set_push(4'b1111, 32'h5010); step();
    set_push(4'b0011, 32'h5020); step();
    idle();
    check("pre_flush_count", 64'(ib_count), 64'd10);
    set_push(4'b1111, 32'h6000);
    num_pops = 2'd3;
    flush    = 1'b1;
    step();
    idle();
    check_empty("flush");
    check("flush_ovf", 64'(overflow_err), 64'd1);

    // pops on an empty buffer are ignored
    num_pops = 2'd3;
    step();
    idle();
    check_empty("epop");
    set_push(4'b0001, 32'h100);
    step();
    idle();
    check("epop_pc0",   64'(dispatch_packets[0].pc), 64'h100);
    check("epop_v0",    64'(dispatch_packets[0].valid), 64'd1);
    check("epop_count", 64'(ib_count), 64'd1);

    // asynchronous reset between edges
    set_push(4'b1111, 32'h7000);
    step();
    idle();
    check("pre_arst_count", 64'(ib_count), 64'd5);
    #2;
    reset = 1'b0;
    #1;
    check_empty("arst");
    check("arst_ovf", 64'(overflow_err), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    step();
    check("post_arst_count", 64'(ib_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
